// File: rtl/bnn_pkg.sv
// Shared types and sizing helpers for the time-multiplexed binary neural network engine.
// Chain layout: hidden fields first, then output fields; each field is weights then threshold (LSB first).
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Offset of the weight and threshold sub-fields within a single neuron field.
    localparam int W_OFS = 0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int chain_len(input int n_in, input int n_hid, input int n_out, input int tw);
        return n_hid * (n_in + tw) + n_out * (n_hid + tw);
    endfunction

    function automatic int thr_ofs(input int n_fan_in);
        return W_OFS + n_fan_in;
    endfunction

    function automatic int hid_base(input int n_in, input int tw, input int h);
        return h * (n_in + tw);
    endfunction

    function automatic int out_base(input int n_in, input int n_hid, input int tw, input int o);
        return n_hid * (n_in + tw) + o * (n_hid + tw);
    endfunction

endpackage

// File: rtl/bnn_seq_engine_if.sv
// Control/data bundle between the pins and the BNN engine: config chain, input chunks, start/result handshake.
// The pin side is the master; the engine is the slave.
interface bnn_seq_engine_if #(
    parameter int N_OUT = 8,
    parameter int XW    = 4,
    parameter int XBW   = 1
);
    logic             cfg_en;
    logic             cfg_bit;
    logic             cfg_out;
    logic             x_valid;
    logic [XBW-1:0]   x_bank;
    logic [XW-1:0]    x_data;
    logic             start;
    logic             busy;
    logic             out_valid;
    logic [N_OUT-1:0] y;

    modport master (
        output cfg_en, cfg_bit, x_valid, x_bank, x_data, start,
        input  cfg_out, busy, out_valid, y
    );

    modport slave (
        input  cfg_en, cfg_bit, x_valid, x_bank, x_data, start,
        output cfg_out, busy, out_valid, y
    );

endinterface

// File: rtl/bnn_xnor_popcount.sv
// One binary neuron, purely combinational: fire = popcount(~(act ^ wgt)) >= thr.
// No latency, no flow control; the count is one bit wider than thr so the compare never wraps.
module bnn_xnor_popcount #(
    parameter int WIDTH = 8,
    parameter int TW    = 4
) (
    input  logic [WIDTH-1:0] act,
    input  logic [WIDTH-1:0] wgt,
    input  logic [TW-1:0]    thr,
    output logic             fire
);

    logic [WIDTH-1:0] agree;
    logic [TW:0]      cnt;

    always_comb begin
        agree = ~(act ^ wgt);
        cnt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{TW{1'b0}}, agree[i]};
        end
        fire = (cnt >= {1'b0, thr});
    end

endmodule

// File: rtl/bnn_seq_engine.sv
// Two-layer BNN evaluating one neuron per cycle; result strobes N_HID+N_OUT+1 cycles after start.
// No backpressure: start is ignored unless IDLE, and cfg_en aborts any computation in flight.
module bnn_seq_engine
    import bnn_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_HID = 8,
    parameter int N_OUT = 8,
    parameter int XW    = 4,
    parameter int TW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bnn_seq_engine_if.slave   bus
);

    localparam int L     = chain_len(N_IN, N_HID, N_OUT, TW);
    localparam int NB    = N_IN / XW;
    localparam int HS    = N_IN + TW;
    localparam int OS    = N_HID + TW;
    localparam int NMAX  = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int IW    = (clog2(NMAX) < 1) ? 1 : clog2(NMAX);
    localparam int HIW   = (clog2(N_HID) < 1) ? 1 : clog2(N_HID);
    localparam int OIW   = (clog2(N_OUT) < 1) ? 1 : clog2(N_OUT);
    localparam logic [IW-1:0] HLAST = IW'(N_HID - 1);
    localparam logic [IW-1:0] OLAST = IW'(N_OUT - 1);

    logic [L-1:0]     chain;
    logic [N_IN-1:0]  x;
    logic [N_HID-1:0] hidden;
    logic [N_OUT-1:0] shadow;
    logic [N_OUT-1:0] shadow_fin;
    logic [N_OUT-1:0] y_q;
    state_t           state;
    logic [IW-1:0]    idx;
    logic             busy_q;
    logic             out_valid_q;

    // Field views of the config chain, one entry per neuron.
    logic [N_IN-1:0]  w_h [N_HID];
    logic [TW-1:0]    t_h [N_HID];
    logic [N_HID-1:0] w_o [N_OUT];
    logic [TW-1:0]    t_o [N_OUT];

    for (genvar g = 0; g < N_HID; g++) begin : g_hid
        assign w_h[g] = chain[hid_base(N_IN, TW, g) + W_OFS +: N_IN];
        assign t_h[g] = chain[hid_base(N_IN, TW, g) + thr_ofs(N_IN) +: TW];
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign w_o[g] = chain[N_HID * HS + g * OS + W_OFS +: N_HID];
        assign t_o[g] = chain[N_HID * HS + g * OS + thr_ofs(N_HID) +: TW];
    end

    logic [HIW-1:0] hsel;
    logic [OIW-1:0] osel;
    logic           h_bit;
    logic           o_bit;

    assign hsel = idx[HIW-1:0];
    assign osel = idx[OIW-1:0];

    bnn_xnor_popcount #(.WIDTH(N_IN), .TW(TW)) u_l1 (
        .act  (x),
        .wgt  (w_h[hsel]),
        .thr  (t_h[hsel]),
        .fire (h_bit)
    );

    bnn_xnor_popcount #(.WIDTH(N_HID), .TW(TW)) u_l2 (
        .act  (hidden),
        .wgt  (w_o[osel]),
        .thr  (t_o[osel]),
        .fire (o_bit)
    );

    // The last output bit is folded in so y can load in the same edge that leaves L2.
    always_comb begin
        shadow_fin       = shadow;
        shadow_fin[osel] = o_bit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain       <= '0;
            x           <= '0;
            hidden      <= '0;
            shadow      <= '0;
            y_q         <= '0;
            state       <= IDLE;
            idx         <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.cfg_en) begin
                chain  <= {chain[L-2:0], bus.cfg_bit};
                x      <= '0;
                state  <= IDLE;
                idx    <= '0;
                busy_q <= 1'b0;
            end else begin
                if (bus.x_valid && !busy_q && (int'(bus.x_bank) < NB)) begin
                    x[int'(bus.x_bank) * XW +: XW] <= bus.x_data;
                end
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state  <= L1;
                            idx    <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                    L1: begin
                        hidden[hsel] <= h_bit;
                        if (idx == HLAST) begin
                            state <= L2;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    L2: begin
                        shadow <= shadow_fin;
                        if (idx == OLAST) begin
                            state       <= DONE;
                            idx         <= '0;
                            y_q         <= shadow_fin;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.cfg_out   = chain[L-1];
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;

endmodule

// File: tb/tb_bnn_seq_engine.sv
// Randomized bench for bnn_seq_engine against a neuron-level reference model of the config chain.
module tb_bnn_seq_engine;
    import bnn_pkg::*;

    localparam int N_IN  = 8;
    localparam int N_HID = 8;
    localparam int N_OUT = 8;
    localparam int XW    = 4;
    localparam int TW    = 4;
    localparam int NB    = N_IN / XW;
    localparam int XBW   = (clog2(NB) < 1) ? 1 : clog2(NB);
    localparam int L     = chain_len(N_IN, N_HID, N_OUT, TW);
    localparam int LAT   = N_HID + N_OUT + 1;

    logic clk;
    logic rst_n;

    bnn_seq_engine_if #(.N_OUT(N_OUT), .XW(XW), .XBW(XBW)) bus ();

    bnn_seq_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .XW(XW), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the chain image as neuron fields, the input word and the last result.
    logic [L-1:0]     m_chain;
    logic [N_IN-1:0]  m_x;
    logic [N_OUT-1:0] m_y;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int field_val(input logic [L-1:0] c, input int base, input int width);
        int v;
        v = 0;
        for (int i = 0; i < width; i++) if (c[base + i]) v += (1 << i);
        return v;
    endfunction

    function automatic logic [N_OUT-1:0] model_eval(input logic [L-1:0] c, input logic [N_IN-1:0] xv);
        logic [N_HID-1:0] h;
        logic [N_OUT-1:0] r;
        int base, cnt;
        for (int n = 0; n < N_HID; n++) begin
            base = n * (N_IN + TW);
            cnt  = 0;
            for (int i = 0; i < N_IN; i++) if (c[base + i] == xv[i]) cnt++;
            h[n] = (cnt >= field_val(c, base + N_IN, TW));
        end
        for (int n = 0; n < N_OUT; n++) begin
            base = N_HID * (N_IN + TW) + n * (N_HID + TW);
            cnt  = 0;
            for (int i = 0; i < N_HID; i++) if (c[base + i] == h[i]) cnt++;
            r[n] = (cnt >= field_val(c, base + N_HID, TW));
        end
        return r;
    endfunction

    function automatic logic [L-1:0] put(input logic [L-1:0] img, input int base, input int width, input int val);
        for (int i = 0; i < width; i++) img[base + i] = val[i];
        return img;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        bus.cfg_en  = 1'b1;
        bus.cfg_bit = b;
        tick();
        m_chain = {m_chain[L-2:0], b};
        m_x     = '0;
    endtask

    // The first bit shifted travels furthest, so the image goes in from its top bit down.
    task automatic load_image(input logic [L-1:0] img);
        for (int k = L - 1; k >= 0; k--) shift_bit(img[k]);
        bus.cfg_en = 1'b0;
    endtask

    task automatic write_chunk(input int bank, input logic [XW-1:0] d);
        bus.x_valid = 1'b1;
        bus.x_bank  = XBW'(bank);
        bus.x_data  = d;
        tick();
        bus.x_valid = 1'b0;
        m_x[bank * XW +: XW] = d;
    endtask

    task automatic run_infer(input string tag, input bit hold_start, input int abort_cyc,
                             input int xv_cyc, input int rst_cyc);
        logic [N_OUT-1:0] y_exp, y_pulse;
        int busy_cnt, pulse_cnt, pulse_cyc, exp_busy;
        logic ab_bit;
        y_exp    = model_eval(m_chain, m_x);
        busy_cnt = 0; pulse_cnt = 0; pulse_cyc = 0; y_pulse = '0; ab_bit = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            if (bus.busy) busy_cnt++;
            if (bus.out_valid) begin
                pulse_cnt++;
                pulse_cyc = c;
                y_pulse   = bus.y;
            end
            bus.start = hold_start;
            if (c == abort_cyc) begin
                ab_bit      = 1'($urandom);
                bus.cfg_en  = 1'b1;
                bus.cfg_bit = ab_bit;
            end
            if (c == xv_cyc) begin
                bus.x_valid = 1'b1;
                bus.x_bank  = '0;
                bus.x_data  = '0;
            end
            if (c == rst_cyc) rst_n = 1'b0;
            tick();
            bus.start   = 1'b0;
            bus.cfg_en  = 1'b0;
            bus.x_valid = 1'b0;
            if (c == abort_cyc) begin
                m_chain = {m_chain[L-2:0], ab_bit};
                m_x     = '0;
                check_val({tag, "_abort_busy"}, bus.busy, 1'b0);
            end
            if (c == rst_cyc) begin
                rst_n = 1'b1;
                check_val({tag, "_rst_busy"}, bus.busy, 1'b0);
                check_val({tag, "_rst_ov"}, bus.out_valid, 1'b0);
                check_val({tag, "_rst_y"}, bus.y, '0);
                check_val({tag, "_rst_cfgout"}, bus.cfg_out, 1'b0);
                m_chain = '0;
                m_x     = '0;
                m_y     = '0;
            end
        end
        if (abort_cyc > 0)    exp_busy = abort_cyc;
        else if (rst_cyc > 0) exp_busy = rst_cyc;
        else                  exp_busy = N_HID + N_OUT;
        check_val({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        if (abort_cyc > 0 || rst_cyc > 0) begin
            check_val({tag, "_no_pulse"}, pulse_cnt, 0);
            check_val({tag, "_y_held"}, bus.y, m_y);
        end else begin
            check_val({tag, "_pulses"}, pulse_cnt, 1);
            check_val({tag, "_pulse_cycle"}, pulse_cyc, LAT);
            check_val({tag, "_y"}, y_pulse, y_exp);
            m_y = y_exp;
        end
    endtask

    logic [L-1:0] img, pat, cap;

    initial begin
        rst_n       = 1'b0;
        bus.cfg_en  = 1'b0;
        bus.cfg_bit = 1'b0;
        bus.x_valid = 1'b0;
        bus.x_bank  = '0;
        bus.x_data  = '0;
        bus.start   = 1'b0;
        m_chain = '0; m_x = '0; m_y = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state, then an all-zero network fires every output.
        check_val("rst_busy", bus.busy, 1'b0);
        check_val("rst_ov", bus.out_valid, 1'b0);
        check_val("rst_y", bus.y, '0);
        check_val("rst_cfgout", bus.cfg_out, 1'b0);
        run_infer("zero", 1'b0, 0, 0, 0);
        check_val("zero_y_ff", bus.y, 8'hFF);

        // Every neuron w=all ones, thr=8: only an all-ones input survives.
        img = '0;
        for (int n = 0; n < N_HID; n++) begin
            img = put(img, n * (N_IN + TW), N_IN, (1 << N_IN) - 1);
            img = put(img, n * (N_IN + TW) + N_IN, TW, 8);
        end
        for (int n = 0; n < N_OUT; n++) begin
            img = put(img, N_HID * (N_IN + TW) + n * (N_HID + TW), N_HID, (1 << N_HID) - 1);
            img = put(img, N_HID * (N_IN + TW) + n * (N_HID + TW) + N_HID, TW, 8);
        end
        load_image(img);
        write_chunk(0, 4'hF);
        write_chunk(1, 4'hF);
        run_infer("ones", 1'b0, 0, 0, 0);
        check_val("ones_y_ff", bus.y, 8'hFF);
        write_chunk(0, 4'hE);
        run_infer("ones_fe", 1'b0, 0, 0, 0);
        check_val("ones_fe_y_00", bus.y, 8'h00);

        // Chain round trip: the pattern re-emerges at cfg_out in shift order.
        for (int k = 0; k < L; k++) pat[k] = 1'($urandom);
        for (int k = 0; k < L; k++) shift_bit(pat[k]);
        cap = '0;
        for (int k = 0; k < L; k++) begin
            cap[k] = bus.cfg_out;
            shift_bit(1'b0);
        end
        bus.cfg_en = 1'b0;
        check_val("chain_roundtrip", cap, pat);

        // Chunked input write and a write dropped during compute.
        for (int k = 0; k < L; k++) img[k] = 1'($urandom);
        for (int n = 0; n < N_HID; n++) img = put(img, n * (N_IN + TW) + N_IN, TW, 4);
        for (int n = 0; n < N_OUT; n++) img = put(img, N_HID * (N_IN + TW) + n * (N_HID + TW) + N_HID, TW, 4);
        load_image(img);
        write_chunk(1, 4'hA);
        write_chunk(0, 4'h5);
        run_infer("xa5", 1'b0, 0, 0, 0);
        check_val("xa5_model", bus.y, model_eval(img, 8'hA5));
        run_infer("xa5_drop", 1'b0, 0, 4, 0);
        check_val("xa5_drop_model", bus.y, model_eval(img, 8'hA5));

        // y=0x3C via output thresholds, then an abort keeps it; start held through busy/DONE.
        for (int k = 0; k < L; k++) img[k] = 1'($urandom);
        for (int n = 0; n < N_OUT; n++)
            img = put(img, N_HID * (N_IN + TW) + n * (N_HID + TW) + N_HID, TW, ((8'h3C >> n) & 1) ? 0 : 15);
        load_image(img);
        run_infer("y3c", 1'b1, 0, 0, 0);
        check_val("y3c_const", bus.y, 8'h3C);
        run_infer("abort", 1'b0, 5, 0, 0);
        check_val("abort_y_3c", bus.y, 8'h3C);

        // start together with cfg_en: the shift wins and nothing starts.
        bus.start = 1'b1;
        shift_bit(1'b1);
        bus.start  = 1'b0;
        bus.cfg_en = 1'b0;
        check_val("start_cfg_busy", bus.busy, 1'b0);
        tick();
        check_val("start_cfg_busy2", bus.busy, 1'b0);

        // Reset mid-L2 clears a chain whose last bit is 1.
        for (int k = 0; k < L; k++) img[k] = 1'($urandom);
        img[L-1] = 1'b1;
        load_image(img);
        check_val("pre_rst_cfgout", bus.cfg_out, 1'b1);
        run_infer("rst_l2", 1'b0, 0, 0, N_HID + 4);
        run_infer("post_rst", 1'b0, 0, 0, 0);
        check_val("post_rst_y_ff", bus.y, 8'hFF);

        // Random networks and inputs, some runs back-to-back.
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < L; k++) img[k] = 1'($urandom);
            for (int n = 0; n < N_HID; n++)
                img = put(img, n * (N_IN + TW) + N_IN, TW, $urandom_range(2, 6));
            for (int n = 0; n < N_OUT; n++)
                img = put(img, N_HID * (N_IN + TW) + n * (N_HID + TW) + N_HID, TW, $urandom_range(2, 6));
            load_image(img);
            for (int r = 0; r < 2; r++) begin
                write_chunk(0, 4'($urandom));
                write_chunk(1, 4'($urandom));
                run_infer("rand", it[0], 0, 0, 0);
                run_infer("rand_b2b", 1'b0, 0, 0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bnn_seq_engine.md
Name: bnn_seq_engine

Overview:
Parametrised, time-multiplexed successor to the fixed 8-8-8 binary neural network.
- Two-layer BNN: N_IN inputs, N_HID hidden neurons, N_OUT outputs.
- Each neuron computes an XNOR-popcount and compares it against a per-neuron programmable threshold.
- Neurons are evaluated one per cycle under an FSM, with start/busy/out_valid handshaking.
- Weights and thresholds are loaded over a serial config chain.
- Sits between the chip I/O pins and the result outputs.

Parameters:
- N_IN, 8, global input bits; must be a multiple of XW.
- N_HID, 8, hidden neurons.
- N_OUT, 8, output neurons.
- XW, 4, input write chunk width.
- TW, 4, threshold width; must satisfy TW >= clog2(max(N_IN,N_HID)+1).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cfg_en  in  1  config shift enable.
- cfg_bit  in  1  serial config data.
- cfg_out  out  1  last bit of the config chain.
- x_valid  in  1  input chunk write strobe.
- x_bank  in  clog2(N_IN/XW) (min 1)  chunk index.
- x_data  in  XW  input chunk.
- start  in  1  request inference.
- busy  out  1  FSM computing.
- out_valid  out  1  one-cycle result strobe.
- y  out  N_OUT  result, held until next completion.

Behaviour:
- Reset (rst_n=0 at a clk edge), applied in every state:
  - All weights, thresholds, x register, hidden register and y go to 0.
  - busy=0, out_valid=0, cfg_out=0, FSM=IDLE.
- Neuron function: out = (popcount(~(in ^ w)) >= thr). Popcount is unsigned; a threshold of 0 always yields 1.
- Config chain:
  - Total length L = N_HID*(N_IN+TW) + N_OUT*(N_HID+TW); default L=192.
  - Each cycle with cfg_en=1, cfg_bit enters hidden neuron 0, bit 0 of its weights, and every bit shifts one place.
  - Per-neuron field order is weights[0..] then thr LSB..MSB.
  - Neurons are chained as hidden 0..N_HID-1, then output 0..N_OUT-1.
  - cfg_out is the final chain bit (output N_OUT-1, thr MSB), so the first bit shifted in reaches cfg_out after L shifts.
  - While cfg_en=1: the x register clears to 0 and x_valid/start are ignored.
- Input register:
  - x_valid=1 with busy=0 and cfg_en=0 writes x[x_bank*XW +: XW] <= x_data.
  - Other chunks are unchanged.
  - Out-of-range x_bank is ignored.
- FSM states IDLE, L1, L2, DONE:
  - IDLE: start=1 (busy=0, cfg_en=0) goes to L1 with idx=0 and busy=1 from the next cycle. The x register is frozen while busy.
  - L1: one cycle per hidden neuron; hidden[idx] <= eval(x, w_h[idx], thr_h[idx]). After idx=N_HID-1, go to L2 with idx=0.
  - L2: one cycle per output neuron; a result shadow register captures each bit. After idx=N_OUT-1, go to DONE.
  - DONE: y <= shadow, out_valid=1 for exactly one cycle, busy=0, return to IDLE.
  - Latency: out_valid is high N_HID+N_OUT+1 cycles after the start edge (17 at defaults). Back-to-back start is accepted in the cycle following DONE.
- Boundary cases:
  - start while busy: ignored.
  - start in DONE: ignored.
  - start and cfg_en together: cfg_en wins.
  - cfg_en=1 while busy: abort. FSM goes to IDLE next cycle, busy=0, no out_valid, y keeps its previous value. Shifting proceeds that cycle.
  - x_valid while busy: dropped.

Decomposition:
- Package bnn_pkg holds:
  - the state enum {IDLE,L1,L2,DONE};
  - function chain_len(N_IN,N_HID,N_OUT,TW);
  - function clog2;
  - the localparam field offsets per layer.
- Sub-module bnn_xnor_popcount (param WIDTH, TW): combinational XNOR, popcount and >= compare. Instantiated once per layer, fed by an idx-selected weight/threshold mux.

Test Plan:
1. Reset, all params 0, x=0, start → y=0xFF; out_valid a single pulse exactly 17 cycles after start; busy high for cycles 1..16.
2. Load every neuron with w=0xFF, thr=8. Write x=0xFF via banks, start → y=0xFF. Then write x=0xFE, start → y=0x00.
3. Shift a 192-bit pseudo-random pattern, then 192 zeros → cfg_out reproduces the pattern bit-exactly during the second 192 cycles.
4. Write x_bank=1 data 0xA, then x_bank=0 data 0x5 → x=0xA5. An x_valid of 0x0 issued mid-compute leaves x=0xA5 and the result unchanged.
5. Set y=0x3C from a prior run, start, assert cfg_en on busy cycle 5 → busy=0 next cycle, no out_valid, y stays 0x3C.
6. Drive rst_n=0 at L2 idx=3 → next cycle busy=0, y=0, out_valid=0, cfg_out=0. A subsequent start with zero params gives y=0xFF.
